alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 4-bit combinational ALU.
- Accepts one operation per transaction through a valid/ready input port.
- Single-cycle logic/arithmetic ops complete in one cycle; shifts and multiply run as iterative multi-cycle ops.
- Results and status flags are held in registers until the consumer accepts them. Sits between the datapath register file and the writeback stage of the 16-bit datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥4 and a power of two.
- SHW (localparam), $clog2(WIDTH), width of the shift amount taken from b[SHW-1:0].

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept an operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B (shift amount in b[SHW-1:0] for shifts).
- opcode  in  3  operation select.
- c_in  in  1  carry in for ADD/SUB.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- c_out  out  1  carry flag.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- overflow  out  1  signed overflow flag.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. While rst_n=0 at a rising edge: state=IDLE; out_valid, result, c_out, zero, negative, overflow all 0; iteration counter 0. in_ready=0 while rst_n=0 and 1 in the first cycle after release. Reset mid-operation aborts the op; no result is emitted.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) or (state==DONE and out_ready).
- Accept: in_valid & in_ready at an edge. a, b, opcode and c_in are captured; inputs are ignored at all other times.

Opcodes:
- 000 ADD: {c_out,result} = a + b + c_in.
- 001 SUB: {c_out,result} = a + ~b + c_in. c_in=1 is a plain subtract; c_out=1 means no borrow.
- 010 AND, 011 OR, 100 XOR: c_out=0.
- 101 SHL: logical left shift by n=b[SHW-1:0]. c_out = last bit shifted out (0 if n=0).
- 110 SHR: logical right shift by n. c_out = last bit shifted out (0 if n=0).
- 111 MUL: unsigned shift-add. result = low WIDTH bits of a*b. c_out=1 iff the high WIDTH bits are nonzero.

Flags:
- overflow = signed overflow for ADD/SUB (operand signs as seen by the adder, i.e. a and ~b for SUB); 0 for all other ops.
- zero and negative derive from the final result for every op.
- All flags update in the same cycle as out_valid rises.

Latency (accept edge = T):
- ADD/SUB/AND/OR/XOR, and shifts with n=0: IDLE→DONE; out_valid=1 after edge T (latency 1).
- Shifts with n>0: IDLE→BUSY; one bit shifted per cycle; DONE after n BUSY cycles; out_valid after edge T+n.
- MUL: BUSY for exactly WIDTH cycles; out_valid after edge T+WIDTH.
- result and flags stay stable while out_valid=1 and out_ready=0.

DONE exit:
- out_ready=1 with no new accept: → IDLE, out_valid=0.
- Simultaneous out_ready and new accept: the new op starts in the same edge. A single-cycle op returns to DONE with new data and out_valid stays 1 (back-to-back throughput of 1/cycle). A multi-cycle op → BUSY with out_valid=0.

Other rules:
- in_valid during BUSY is not accepted (in_ready=0); the source must hold it.
- Opcode is decoded only from the captured copy; input changes during BUSY have no effect.

Test Plan:
- ADD, WIDTH=16: a=0xFFFF, b=0x0001, c_in=0 → 1 cycle later result=0x0000, c_out=1, zero=1, overflow=0. a=0x7FFF, b=0x0001 → result=0x8000, negative=1, overflow=1.
- SUB: a=0x0005, b=0x0007, c_in=1 → result=0xFFFE, c_out=0, negative=1. a=0x8000, b=0x0001 → result=0x7FFF, overflow=1.
- SHL: a=0x8001, b=0x0004 → out_valid exactly 4 cycles after accept, result=0x0010, c_out=0. SHR: a=0x0003, b=0x0001 → result=0x0001, c_out=1. SHL with b=0 → latency 1, result=a, c_out=0.
- MUL: a=0x0100, b=0x0100 → out_valid 16 cycles after accept, result=0x0000, c_out=1, zero=1. a=0x00FF, b=0x0003 → result=0x02FD, c_out=0.
- Handshake: hold out_ready=0 for 5 cycles → result/flags stable, in_ready=0. Then out_ready=1 with a pending AND (a=0xF0F0, b=0xFF00) → AND result=0xF000 next cycle, out_valid continuous. in_valid pulses during MUL BUSY are not accepted.
- Reset: drive rst_n=0 mid-MUL (cycle 8) → next edge out_valid=0, result=0, flags 0. After release, in_ready=1; an ADD 2+3 (c_in=0) yields 0x0005 with latency 1.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operation handshake in, result/flags handshake out.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       opcode;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             zero;
    logic             negative;
    logic             overflow;

    modport master (
        output in_valid, a, b, opcode, c_in, out_ready,
        input  in_ready, out_valid, result, c_out, zero, negative, overflow
    );

    modport slave (
        input  in_valid, a, b, opcode, c_in, out_ready,
        output in_ready, out_valid, result, c_out, zero, negative, overflow
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle add/sub/logic, iterative shifts (1 bit/cycle) and shift-add multiply.
// Result and flags are held in registers until the consumer takes them.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input logic     clk,
    input logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR = 3'b011,
                           OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110, OP_MUL = 3'b111;
    localparam logic [SHW:0] MUL_ITERS = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] LAST_ITER = (SHW+1)'(1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic             ready_w, accept, multi, load_res;
    logic [SHW-1:0]   shamt;
    logic [2:0]       op_q;
    logic [SHW:0]     cnt_q;
    logic [WIDTH-1:0] a_q, work_q, p_hi_q;
    logic [WIDTH-1:0] result_q, res_d, alu_res, b_eff;
    logic             c_out_q, zero_q, neg_q, ovf_q, c_d, v_d, alu_c, alu_v;
    logic [WIDTH:0]   sum, mac;
    logic [WIDTH-1:0] sh_next, hi_next, lo_next;
    logic             sh_bit;

    function automatic logic add_ovf(input logic signed [WIDTH-1:0] x, input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] s);
        return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    assign shamt   = bus.b[SHW-1:0];
    assign ready_w = rst_n && ((state_q == IDLE) || (state_q == DONE && bus.out_ready));
    assign accept  = bus.in_valid && ready_w;

    always_comb begin
        b_eff   = (bus.opcode == OP_SUB) ? ~bus.b : bus.b;
        sum     = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.c_in};
        alu_res = bus.a;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.opcode)
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = add_ovf(bus.a, b_eff, sum[WIDTH-1:0]);
            end
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            default: ; // zero-distance shifts pass a through; MUL never completes here
        endcase
        multi = (bus.opcode == OP_MUL) ||
                ((bus.opcode == OP_SHL || bus.opcode == OP_SHR) && shamt != '0);
    end

    // work_q holds the shifting operand, or the multiplier / low product half for MUL
    always_comb begin
        sh_next = (op_q == OP_SHL) ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};
        sh_bit  = (op_q == OP_SHL) ? work_q[WIDTH-1] : work_q[0];
        mac     = {1'b0, p_hi_q} + (work_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        hi_next = mac[WIDTH:1];
        lo_next = {mac[0], work_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        load_res = 1'b0;
        res_d    = alu_res;
        c_d      = alu_c;
        v_d      = alu_v;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d  = multi ? BUSY : DONE;
                    load_res = !multi;
                end else if (state_q == DONE && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                v_d   = 1'b0;
                res_d = (op_q == OP_MUL) ? lo_next : sh_next;
                c_d   = (op_q == OP_MUL) ? (|hi_next) : sh_bit;
                if (cnt_q == LAST_ITER) begin
                    state_d  = DONE;
                    load_res = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            c_out_q  <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (load_res) begin
                result_q <= res_d;
                c_out_q  <= c_d;
                zero_q   <= (res_d == '0);
                neg_q    <= res_d[WIDTH-1];
                ovf_q    <= v_d;
            end
            if (accept)                cnt_q <= (bus.opcode == OP_MUL) ? MUL_ITERS : {1'b0, shamt};
            else if (state_q == BUSY)  cnt_q <= cnt_q - LAST_ITER;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= bus.opcode;
            a_q    <= bus.a;
            work_q <= (bus.opcode == OP_MUL) ? bus.b : bus.a;
            p_hi_q <= '0;
        end else if (state_q == BUSY) begin
            if (op_q == OP_MUL) begin
                p_hi_q <= hi_next;
                work_q <= lo_next;
            end else begin
                work_q <= sh_next;
            end
        end
    end

    assign bus.in_ready  = ready_w;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.c_out     = c_out_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = neg_q;
    assign bus.overflow  = ovf_q;
endmodule
